plane_surf_accum: RTL

//  Downstream stage of triag_surf_calc. Sums N_TRIAG consecutive triangle surfaces (one per surf_valid

---
 rtl/plane_calc_pkg.sv | 10 +
 rtl/sat_accum.sv | 17 +
 rtl/plane_surf_accum.sv | 84 ++++++++
 3 files changed

// File: rtl/plane_calc_pkg.sv
// Shared widths and types for the scan-plane area stages.
package plane_calc_pkg;
    localparam int N_TRIAG_DEF = 8;
    localparam int SURF_W_DEF  = 32;
    localparam int AREA_W_DEF  = 40;
    localparam int CNT_W       = $clog2(N_TRIAG_DEF);

    typedef logic [SURF_W_DEF-1:0] surf_t;
    typedef logic [AREA_W_DEF-1:0] area_t;
endpackage

// File: rtl/sat_accum.sv
// Saturating unsigned adder: sum clamps to all-ones when the add carries out.
// Latency: combinational.
// Backpressure: none.
module sat_accum #(
    parameter int AREA_W = 40
) (
    input  logic [AREA_W-1:0] acc,
    input  logic [AREA_W-1:0] addend,
    output logic [AREA_W-1:0] sum,
    output logic              carry
);
    logic [AREA_W:0] full;

    assign full  = {1'b0, acc} + {1'b0, addend};
    assign carry = full[AREA_W];
    assign sum   = carry ? {AREA_W{1'b1}} : full[AREA_W-1:0];
endmodule

// File: rtl/plane_surf_accum.sv
// Sums N_TRIAG triangle surfaces per frame into plane area, tracks peak and overflow.
// Latency: area_valid strobes the cycle after the last triangle of a frame.
// Backpressure: none; a surface is accepted on every surf_valid cycle.
module plane_surf_accum
    import plane_calc_pkg::*;
#(
    parameter int N_TRIAG = N_TRIAG_DEF,
    parameter int SURF_W  = SURF_W_DEF,
    parameter int AREA_W  = AREA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       surf_valid,
    input  logic [SURF_W-1:0]          surf,
    output logic                       busy,
    output logic [$clog2(N_TRIAG)-1:0] tri_cnt,
    output logic                       area_valid,
    output logic [AREA_W-1:0]          area,
    output logic [SURF_W-1:0]          peak,
    output logic                       area_ovf
);
    localparam int CW = $clog2(N_TRIAG);
    localparam logic [CW-1:0] LAST = CW'(N_TRIAG - 1);

    logic [AREA_W-1:0] acc;
    logic [SURF_W-1:0] pk;
    logic              ovf;

    logic [AREA_W-1:0] sum;
    logic              carry;
    logic [SURF_W-1:0] pk_nxt;
    logic              last;

    sat_accum #(.AREA_W(AREA_W)) u_sat (
        .acc    (acc),
        .addend (AREA_W'(surf)),
        .sum    (sum),
        .carry  (carry)
    );

    assign pk_nxt = (surf > pk) ? surf : pk;
    assign last   = (tri_cnt == LAST);
    assign busy   = (tri_cnt != '0);

    // The closing triangle goes straight to the result registers so the
    // accumulator is free for a new frame on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            pk         <= '0;
            ovf        <= 1'b0;
            tri_cnt    <= '0;
            area       <= '0;
            peak       <= '0;
            area_ovf   <= 1'b0;
            area_valid <= 1'b0;
        end else begin
            area_valid <= 1'b0;
            if (clr) begin
                acc     <= '0;
                pk      <= '0;
                ovf     <= 1'b0;
                tri_cnt <= '0;
            end else if (surf_valid) begin
                if (last) begin
                    area       <= sum;
                    peak       <= pk_nxt;
                    area_ovf   <= ovf | carry;
                    area_valid <= 1'b1;
                    acc        <= '0;
                    pk         <= '0;
                    ovf        <= 1'b0;
                    tri_cnt    <= '0;
                end else begin
                    acc     <= sum;
                    pk      <= pk_nxt;
                    ovf     <= ovf | carry;
                    tri_cnt <= tri_cnt + 1'b1;
                end
            end
        end
    end
endmodule
